// File: rtl/neuron_pkg.sv
// Shared definitions for the leaky integrate-and-fire neuron: FSM encoding and default tuning.
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_INTEG   = 2'd0,
    ST_FIRE    = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ACC_W       = 12;
  localparam int DEF_THRESH      = 200;
  localparam int DEF_LEAK_SHIFT  = 3;
  localparam int DEF_REFRACT_CYC = 4;
  localparam int SPIKE_CNT_W     = 8;
  localparam int REFR_W          = 4;

endpackage

// File: rtl/neuron_sat_alu.sv
// Combinational membrane update: optional leak, then saturating add or floored subtract.
module neuron_sat_alu #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 12,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [ACC_W-1:0]  i_v_mem,
  input  logic              i_leak_en,
  input  logic              i_add_en,
  input  logic              i_inhib,
  input  logic [DATA_W-1:0] i_data,
  output logic [ACC_W-1:0]  o_v_next
);

  localparam int EXT = ACC_W + 1 - DATA_W;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{EXT{1'b0}}, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] floor_sub(input logic [ACC_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [ACC_W:0] d;
    d = {1'b0, a} - {{EXT{1'b0}}, b};
    return d[ACC_W] ? {ACC_W{1'b0}} : d[ACC_W-1:0];
  endfunction

  logic [ACC_W-1:0] w_v_lk;

  // Leak is applied before the synaptic input so both in one cycle compose predictably.
  assign w_v_lk = i_leak_en ? (i_v_mem - (i_v_mem >> LEAK_SHIFT)) : i_v_mem;

  always_comb begin
    o_v_next = w_v_lk;
    if (i_add_en) begin
      o_v_next = i_inhib ? floor_sub(w_v_lk, i_data) : sat_add(w_v_lk, i_data);
    end
  end

endmodule

// File: rtl/neuron_accum.sv
// Integrate-and-fire neuron: accumulates synaptic words, fires one-cycle spikes,
// then stays refractory (inputs dropped) for REFRACT_CYC cycles.
module neuron_accum
  import neuron_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int THRESH      = DEF_THRESH,
  parameter int LEAK_SHIFT  = DEF_LEAK_SHIFT,
  parameter int REFRACT_CYC = DEF_REFRACT_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_inhib,
  input  logic                   leak_en,
  output logic                   in_ready,
  output logic                   spike,
  output logic [ACC_W-1:0]       v_mem,
  output logic [SPIKE_CNT_W-1:0] spike_cnt
);

  localparam logic [ACC_W-1:0]  THR_L     = ACC_W'(THRESH);
  localparam logic [REFR_W-1:0] REFR_LOAD = REFR_W'(REFRACT_CYC - 1);

  state_t                  r_state;
  logic [ACC_W-1:0]        r_v_mem;
  logic [SPIKE_CNT_W-1:0]  r_spike_cnt;
  logic [REFR_W-1:0]       r_refr;
  logic                    w_accept;
  logic [ACC_W-1:0]        w_v_next;

  assign in_ready  = (r_state == ST_INTEG);
  assign spike     = (r_state == ST_FIRE);
  assign v_mem     = r_v_mem;
  assign spike_cnt = r_spike_cnt;
  assign w_accept  = in_valid && in_ready;

  neuron_sat_alu #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_alu (
    .i_v_mem  (r_v_mem),
    .i_leak_en(leak_en),
    .i_add_en (w_accept),
    .i_inhib  (in_inhib),
    .i_data   (in_data),
    .o_v_next (w_v_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INTEG;
      r_v_mem     <= '0;
      r_spike_cnt <= '0;
      r_refr      <= '0;
    end else begin
      case (r_state)
        ST_INTEG: begin
          r_v_mem <= w_v_next;
          if (w_v_next >= THR_L) r_state <= ST_FIRE;
        end
        ST_FIRE: begin
          r_v_mem     <= '0;
          r_spike_cnt <= r_spike_cnt + 8'd1;
          r_refr      <= REFR_LOAD;
          r_state     <= ST_REFRACT;
        end
        ST_REFRACT: begin
          // Counter runs REFRACT_CYC-1 down to 0, giving exactly REFRACT_CYC cycles here.
          if (r_refr == '0) r_state <= ST_INTEG;
          else              r_refr  <= r_refr - 1'b1;
        end
        default: r_state <= ST_INTEG;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accum.sv
// Bench for neuron_accum: directed scenarios plus random traffic against an integer reference model.
module tb_neuron_accum;
  localparam int R    = 4;
  localparam int LS   = 3;
  localparam int VMAX = 4095;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_inhib, leak_en;
  logic [7:0] in_data;
  logic       rdy_a, spk_a, rdy_b, spk_b;
  logic [11:0] vm_a, vm_b;
  logic [7:0]  cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;

  // Reference state per instance: membrane, cycles of input blocking left, spike count.
  int m_v[2];
  int m_blk[2];
  int m_cnt[2];
  int m_thr[2];

  neuron_accum #(.THRESH(200)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_inhib(in_inhib),
    .leak_en(leak_en), .in_ready(rdy_a), .spike(spk_a), .v_mem(vm_a), .spike_cnt(cnt_a));

  neuron_accum #(.THRESH(4095)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_inhib(in_inhib),
    .leak_en(leak_en), .in_ready(rdy_b), .spike(spk_b), .v_mem(vm_b), .spike_cnt(cnt_b));

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_blk[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int v;
      if (m_blk[k] == 0) begin
        v = m_v[k];
        if (leak_en) v = v - (v / (1 << LS));
        if (in_valid) begin
          if (in_inhib) v = (int'(in_data) > v) ? 0 : v - int'(in_data);
          else          v = (v + int'(in_data) > VMAX) ? VMAX : v + int'(in_data);
        end
        m_v[k] = v;
        if (v >= m_thr[k]) m_blk[k] = R + 1;
      end else begin
        if (m_blk[k] == R + 1) begin
          m_v[k] = 0;
          m_cnt[k] = (m_cnt[k] + 1) % 256;
        end
        m_blk[k]--;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic inh, input logic lk);
    @(negedge clk);
    in_valid = v; in_data = d; in_inhib = inh; leak_en = lk;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inhib = 1'b0; leak_en = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (spk_a !== 1'b0) begin bad++; $display("FAIL reset_spike got=%0b exp=0", spk_a); end
    total++; if (vm_a !== 12'd0) begin bad++; $display("FAIL reset_vmem got=%0d exp=0", vm_a); end
    total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
    do_reset();
    #1;
    total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", rdy_a); end
  endtask

  task automatic test_excite();
    do_reset();
    cyc(1, 8'd100, 0, 0);
    total++; if (vm_a !== 12'd100 || spk_a !== 1'b0) begin bad++; $display("FAIL exc_first got v=%0d s=%0b exp v=100 s=0", vm_a, spk_a); end
    cyc(1, 8'd100, 0, 0);
    total++; if (vm_a !== 12'd200 || spk_a !== 1'b1) begin bad++; $display("FAIL exc_fire got v=%0d s=%0b exp v=200 s=1", vm_a, spk_a); end
    cyc(0, 8'd0, 0, 0);
    total++; if (vm_a !== 12'd0 || spk_a !== 1'b0 || cnt_a !== 8'd1) begin bad++; $display("FAIL exc_after got v=%0d s=%0b c=%0d exp v=0 s=0 c=1", vm_a, spk_a, cnt_a); end
  endtask

  task automatic test_inhibit();
    do_reset();
    cyc(1, 8'd50, 0, 0);
    total++; if (vm_a !== 12'd50) begin bad++; $display("FAIL inh_setup got=%0d exp=50", vm_a); end
    cyc(1, 8'd100, 1, 0);
    total++; if (vm_a !== 12'd0 || spk_a !== 1'b0) begin bad++; $display("FAIL inh_floor got v=%0d s=%0b exp v=0 s=0", vm_a, spk_a); end
    cyc(0, 8'd0, 0, 0);
    total++; if (spk_a !== 1'b0 || rdy_a !== 1'b1) begin bad++; $display("FAIL inh_nospike got s=%0b r=%0b exp s=0 r=1", spk_a, rdy_a); end
  endtask

  task automatic test_leak();
    do_reset();
    cyc(1, 8'd160, 0, 0);
    cyc(0, 8'd0, 0, 1);
    total++; if (vm_a !== 12'd140) begin bad++; $display("FAIL leak_only got=%0d exp=140", vm_a); end
    do_reset();
    cyc(1, 8'd160, 0, 0);
    cyc(1, 8'd64, 0, 1);
    total++; if (vm_a !== 12'd204 || spk_a !== 1'b1) begin bad++; $display("FAIL leak_then_add got v=%0d s=%0b exp v=204 s=1", vm_a, spk_a); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(1, 8'd255, 0, 0);
      total++; if (vm_b !== 12'(m_v[1])) begin bad++; $display("FAIL sat_step%0d got=%0d exp=%0d", i, vm_b, m_v[1]); end
    end
    total++; if (vm_b !== 12'd4095 || spk_b !== 1'b1) begin bad++; $display("FAIL sat_fire got v=%0d s=%0b exp v=4095 s=1", vm_b, spk_b); end
    cyc(0, 8'd0, 0, 0);
    total++; if (vm_b !== 12'd0 || cnt_b !== 8'd1) begin bad++; $display("FAIL sat_after got v=%0d c=%0d exp v=0 c=1", vm_b, cnt_b); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1, 8'd100, 0, 0);
    cyc(1, 8'd100, 0, 0);
    total++; if (rdy_a !== 1'b0 || spk_a !== 1'b1) begin bad++; $display("FAIL bp_fire got r=%0b s=%0b exp r=0 s=1", rdy_a, spk_a); end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'd50, 0, 0);
      total++; if (rdy_a !== 1'b0 || vm_a !== 12'd0) begin bad++; $display("FAIL bp_drop%0d got r=%0b v=%0d exp r=0 v=0", i, rdy_a, vm_a); end
    end
    cyc(1, 8'd50, 0, 0);
    total++; if (rdy_a !== 1'b1 || vm_a !== 12'd0) begin bad++; $display("FAIL bp_release got r=%0b v=%0d exp r=1 v=0", rdy_a, vm_a); end
    cyc(1, 8'd50, 0, 0);
    total++; if (vm_a !== 12'd50) begin bad++; $display("FAIL bp_resume got=%0d exp=50", vm_a); end
  endtask

  task automatic test_rst_refract();
    do_reset();
    cyc(1, 8'd100, 0, 0);
    cyc(1, 8'd100, 0, 0);
    cyc(0, 8'd0, 0, 0);
    cyc(0, 8'd0, 0, 0);
    total++; if (cnt_a !== 8'd1 || rdy_a !== 1'b0) begin bad++; $display("FAIL rr_pre got c=%0d r=%0b exp c=1 r=0", cnt_a, rdy_a); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (cnt_a !== 8'd0 || spk_a !== 1'b0 || vm_a !== 12'd0 || rdy_a !== 1'b1) begin bad++; $display("FAIL rr_async got c=%0d s=%0b v=%0d r=%0b exp 0 0 0 1", cnt_a, spk_a, vm_a, rdy_a); end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    cyc(0, 8'd0, 0, 0);
    total++; if (cnt_a !== 8'd0 || spk_a !== 1'b0 || rdy_a !== 1'b1) begin bad++; $display("FAIL rr_post got c=%0d s=%0b r=%0b exp 0 0 1", cnt_a, spk_a, rdy_a); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cyc(1, 8'd200, 0, 0);
      repeat (5) cyc(0, 8'd0, 0, 0);
      if (i == 254) begin
        total++; if (cnt_a !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", cnt_a); end
      end
    end
    total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", cnt_a); end
    total++; if (cnt_b !== 8'(m_cnt[1])) begin bad++; $display("FAIL wrap_b got=%0d exp=%0d", cnt_b, m_cnt[1]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0, ($urandom % 4) == 0);
      total++;
      if (vm_a !== 12'(m_v[0]) || spk_a !== (m_blk[0] == R + 1) || rdy_a !== (m_blk[0] == 0) || cnt_a !== 8'(m_cnt[0])) begin
        bad++;
        $display("FAIL rand_a cyc=%0d got v=%0d s=%0b r=%0b c=%0d exp v=%0d s=%0b r=%0b c=%0d", i, vm_a, spk_a, rdy_a, cnt_a,
                 m_v[0], (m_blk[0] == R + 1), (m_blk[0] == 0), m_cnt[0]);
      end
      total++;
      if (vm_b !== 12'(m_v[1]) || cnt_b !== 8'(m_cnt[1])) begin
        bad++;
        $display("FAIL rand_b cyc=%0d got v=%0d c=%0d exp v=%0d c=%0d", i, vm_b, cnt_b, m_v[1], m_cnt[1]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inhib = 1'b0; leak_en = 1'b0;
    m_thr[0] = 200;
    m_thr[1] = 4095;
    model_clear();
    test_reset();
    test_excite();
    test_inhibit();
    test_leak();
    test_saturate();
    test_back_to_back();
    test_rst_refract();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
